fifo_word_splitter: RTL
=======================

# fifo_word_splitter

Upstream feeder for the 16-deep, 4-bit synchronous FIFO. It accepts wide words from a producer over a valid/ready handshake, splits each word into 4-bit nibbles, and writes them into the FIFO one per cycle, respecting `full`. It is the only driver of the FIFO's shared `en` line, so it drops `en` whenever it has nothing to write. The FIFO then drains one entry per cycle whenever it is not empty.

## Interface
Parameters:
- `NIBBLES`, default 4: nibbles per input word; must be ≥ 2. Input word width is `4*NIBBLES`.

Ports:
- `clk`  input  1: single clock; all logic on posedge.
- `rst`  input  1: reset, synchronous, active-low (`rst==0` resets on the next posedge).
- `in_valid`  input  1: producer has a word on `in_data`.
- `in_data`  input  `4*NIBBLES`: word to split.
- `in_ready`  output  1: a word is accepted on a cycle with `in_valid && in_ready`.
- `fifo_full`  input  1: FIFO `full` flag.
- `fifo_en`  output  1: FIFO `en`; 1 = write `fifo_data`.
- `fifo_data`  output  4: nibble to FIFO `data_in`.
- `busy`  output  1: a word is held and not fully written.
- `word_cnt`  output  8: count of words fully written since reset; wraps 255→0.

## Operation
- States:
  - IDLE: no word held.
  - SEND: a word is held in `hold` with nibble index `idx` (0..NIBBLES-1).
- Acceptance:
  - IDLE: `in_ready=1`. On `in_valid`: `hold<=in_data`, `idx<=0`, go to SEND.
  - SEND: `in_ready=1` only when `idx==NIBBLES-1 && !fifo_full`, i.e. the cycle the last nibble is written. An accept in that cycle reloads `hold`, sets `idx<=0` and stays in SEND, giving back-to-back words with no bubble.
  - Otherwise `in_ready=0`.
- Write:
  - In SEND: `fifo_en = !fifo_full`; `fifo_data` = nibble `idx` of `hold`.
  - On a write, `idx<=idx+1`. The last nibble either returns the block to IDLE or reloads as above, and increments `word_cnt`.
- Backpressure: while `fifo_full` is high in SEND:
  - `fifo_en=0`, which lets the FIFO read and free a slot.
  - `idx` and `hold` are frozen; `fifo_data` is held stable.
  - No nibble is lost or duplicated.
- IDLE outputs: `fifo_en=0`, `fifo_data=0`.
- Status: `busy = (state==SEND)`.
- Inputs with `in_valid=0` are ignored; `in_data` is sampled only on accept.

## Timing
- Reset (`rst==0` at a posedge):
  - State: IDLE; `idx=0`, `hold=0`, `word_cnt=0`.
  - While `rst` is low, outputs are forced to `in_ready=0`, `fifo_en=0`, `fifo_data=0`, `busy=0`.
- Reset mid-word: the held word is discarded and its remaining nibbles are never written. `word_cnt` is not incremented for it.
- `fifo_en` and `fifo_data` are combinational from registered state plus `fifo_full`, with no added latency. The FIFO samples them on the same posedge.
- Latency: the first nibble is presented on the cycle after accept. An unstalled word occupies exactly NIBBLES consecutive `fifo_en` cycles.
- Throughput: 1 nibble/cycle, i.e. 1 word per NIBBLES cycles with `in_valid` held high.
- `fifo_full` toggling every cycle: write only on cycles where it is low; order is preserved.

## Configuration
- `SPLIT_LSB_FIRST_EN` undefined: nibble `idx` = bits `[4*(NIBBLES-idx)-1 -: 4]`, most-significant nibble written first.
- `SPLIT_LSB_FIRST_EN` defined: nibble `idx` = bits `[4*idx+3 -: 4]`, least-significant nibble written first.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use `NIBBLES=4`; the macro is undefined unless stated.
- Reset, then `in_data=16'hA5C3` for one cycle with `fifo_full=0` → `fifo_en` high for 4 consecutive cycles with `fifo_data` A,5,C,3. Afterwards `word_cnt=1`, `busy=0`.
- `in_valid` held with 16'h1234 then 16'h5678, `fifo_full=0` → 8 consecutive write cycles 1,2,3,4,5,6,7,8. `in_ready` is high only in IDLE and on the cycle nibble 4 is written. `word_cnt=2`.
- 16'hA5C3 with `fifo_full` high for 3 cycles after nibble 5 is written → `fifo_en=0` and `fifo_data=C` across the stall, then C,3 are written. Exactly 4 writes in total.
- Accept 16'hBEEF, drive `rst=0` after B,E are written → next cycle IDLE, `fifo_en=0`, `word_cnt=0`. E,F are never written.
- FIFO driven to full from IDLE, then 16'h0F0F offered → accepted, `busy=1`, `fifo_en=0` until full drops, then 0,F,0,F.
- `SPLIT_LSB_FIRST_EN` defined, 16'hA5C3 → writes 3,C,5,A.

Source files
------------

// File: rtl/fifo_word_splitter.sv
// Splits 4*NIBBLES-bit words into nibbles and writes them into a 4-bit FIFO one per cycle.
// Optional build macro SPLIT_LSB_FIRST_EN selects least-significant-nibble-first order.
module fifo_word_splitter #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [4*NIBBLES-1:0]   in_data,
  output logic                   in_ready,
  input  logic                   fifo_full,
  output logic                   fifo_en,
  output logic [3:0]             fifo_data,
  output logic                   busy,
  output logic [7:0]             word_cnt
);

  localparam int DATA_W = 4 * NIBBLES;
  localparam int IDX_W  = $clog2(NIBBLES);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_nxt;
  logic [DATA_W-1:0]   hold;
  logic [IDX_W-1:0]    idx;
  logic [7:0]          cnt;
  logic                last, wr, rdy, accept;

  function automatic logic [3:0] nibble_sel(input logic [DATA_W-1:0] w,
                                            input logic [IDX_W-1:0]  i);
    int k;
    k = int'(i);
`ifdef SPLIT_LSB_FIRST_EN
    nibble_sel = w[4*k +: 4];
`else
    nibble_sel = w[4*(NIBBLES-1-k) +: 4];
`endif
  endfunction

  assign last   = (idx == IDX_W'(NIBBLES-1));
  assign wr     = (state == SEND) && !fifo_full;
  // The last-nibble write cycle doubles as an accept slot so words stream without a bubble.
  assign rdy    = (state == IDLE) || (wr && last);
  assign accept = in_valid && rdy;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = SEND;
      SEND: if (wr && last) state_nxt = in_valid ? SEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    fifo_en   = 1'b0;
    fifo_data = 4'd0;
    busy      = 1'b0;
    if (rst) begin
      in_ready = rdy;
      if (state == SEND) begin
        busy      = 1'b1;
        fifo_en   = !fifo_full;
        fifo_data = nibble_sel(hold, idx);
      end
    end
  end

  // Word holding register, nibble index and completed-word counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      hold <= '0;
      idx  <= '0;
      cnt  <= 8'd0;
    end else begin
      if (accept) begin
        hold <= in_data;
        idx  <= '0;
      end else if (wr) begin
        idx  <= idx + IDX_W'(1);
      end
      if (wr && last) cnt <= cnt + 8'd1;
    end
  end

  assign word_cnt = cnt;

endmodule
